// File: rtl/instr_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the instruction memory and its byte-stream loader.
// The memory geometry and the loader state enumeration live here so that the
// memory, the loader and the word assembler all agree on them.
//
// Contents:
//   IMEM_DEPTH     instruction memory depth in 32-bit words
//   WORD_BYTES     bytes per instruction word
//   LANE_W         width of a byte-lane index inside one word
//   COUNT_W        width of the loader word counter (holds 0..IMEM_DEPTH)
//   loader_state_t IDLE / LOAD / DONE session states
//   place_byte()   positions a byte in its big-endian lane of a word
// ----------------------------------------------------------------------------
package instr_mem_loader_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int COUNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // Lane 0 is the most significant byte, so each further lane moves the
  // byte eight bits further down the word.
  function automatic logic [31:0] place_byte(input logic [7:0]        b,
                                             input logic [LANE_W-1:0] lane);
    logic [31:0] w;
    w = {b, 24'h000000} >> {lane, 3'b000};
    return w;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
// Packs accepted bytes big-endian into a 32-bit word. The first byte of a
// word lands in [31:24], the last in [7:0]. A word is complete when its
// final lane is filled or when the offered byte is marked as the last byte
// of the image; lanes not yet filled at that point read as zero because the
// holding register is cleared after every completed word.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset, discards any partial word
//   i_clear      start of a new session: drop the partial word, lane 0
//   i_accept     a byte is being accepted this cycle
//   i_byte       the accepted byte
//   i_last       the accepted byte is the final byte of the image
//   o_word_done  this cycle's accepted byte completes a word
//   o_word       the word including this cycle's byte (valid with o_word_done)
// ----------------------------------------------------------------------------
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_done,
  output logic [31:0] o_word
);

  logic [31:0]       r_word;
  logic [LANE_W-1:0] r_lane;
  logic [31:0]       w_merged;
  logic              w_lane_full;

  // The current byte is merged combinationally so the loader can register
  // the finished word on the same edge that accepts its final byte.
  assign w_merged    = r_word | place_byte(i_byte, r_lane);
  assign w_lane_full = (r_lane == LANE_W'(WORD_BYTES - 1));
  assign o_word_done = i_accept && (i_last || w_lane_full);
  assign o_word      = w_merged;

  // Holding register and lane index. A completed word is handed off to the
  // loader, so the register returns to zero ready to zero-fill the next one.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_word <= 32'h0;
      r_lane <= '0;
    end else if (i_accept) begin
      if (o_word_done) begin
        r_word <= 32'h0;
        r_lane <= '0;
      end else begin
        r_word <= w_merged;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Streams a byte image into instruction memory one 32-bit word at a time.
// A session starts with a one-cycle start pulse, accepts at most one byte
// per cycle while in LOAD, and ends in DONE once the image's final byte has
// been written or the memory is full. The write port is fully registered.
// DEPTH must stay within 1..63 so the 6-bit word counter can reach DEPTH.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle request to begin (or restart) a load session
//   byte_valid  a byte is offered on byte_data
//   byte_data   offered byte
//   byte_last   offered byte is the final byte of the image
//   byte_ready  loader accepts the offered byte this cycle (state LOAD)
//   wr_en       one-cycle write strobe to instruction memory
//   wr_addr     word-aligned byte address of the written word
//   wr_data     word being written
//   busy        session is in LOAD
//   done        session is in DONE
//   word_count  words written in the current session
// ----------------------------------------------------------------------------
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [31:0]        wr_data,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] word_count
);

  loader_state_t      r_state;
  logic [COUNT_W-1:0] r_word_count;
  logic               r_wr_en;
  logic [AW-1:0]      r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_clear;
  logic               w_word_done;
  logic [31:0]        w_word;
  logic               w_last_slot;
  logic               w_final_write;

  // Readiness depends on the state alone, so a byte offered in the cycle
  // after the final write is already refused.
  assign byte_ready    = (r_state == ST_LOAD);
  assign w_accept      = byte_valid && byte_ready;
  assign w_clear       = start && (r_state != ST_LOAD);
  assign w_last_slot   = (r_word_count == COUNT_W'(DEPTH - 1));
  assign w_final_write = w_word_done && (byte_last || w_last_slot);

  word_assembler u_word_assembler (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_byte      (byte_data),
    .i_last      (byte_last),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  // Session FSM, word counter and write port. The write, the counter step
  // and the move to DONE all take effect on the edge that accepts the byte
  // completing a word, so word_count already shows the new total while
  // wr_en is high. Address and data hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_word_count <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_word_done) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= AW'({r_word_count, 2'b00});
            r_wr_data    <= w_word;
            r_word_count <= r_word_count + 1'b1;
          end
          if (w_final_write) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. A reference model tracks the
// session from the byte stream alone (bytes collected per word, word index,
// whether the session is still accepting) and predicts every memory write.
// A monitor records each write the loader actually issues.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;

  int checks = 0;
  int errors = 0;

  // Reference model of the session
  bit          mActive;
  bit          mDone;
  int          mWordCount;
  logic [7:0]  mBytes[$];
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];

  // Writes observed from the loader
  logic [31:0] capAddr[$];
  logic [31:0] capData[$];
  logic [5:0]  capCount[$];

  instr_mem_loader #(.DEPTH(32), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write on the falling edge, well away from the active edge
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      capAddr.push_back(wr_addr);
      capData.push_back(wr_data);
      capCount.push_back(word_count);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Model: a byte the session accepts joins the current word; four bytes or
  // a last byte finish the word, and a last byte or a full memory ends it.
  function automatic void modelAccept(input logic [7:0] b, input bit last);
    logic [31:0] word;
    mBytes.push_back(b);
    if (mBytes.size() == 4 || last) begin
      word = 32'h0;
      for (int i = 0; i < mBytes.size(); i++)
        word = word | (32'(mBytes[i]) << (24 - 8 * i));
      expAddr.push_back(32'(mWordCount * 4));
      expData.push_back(word);
      mWordCount++;
      mBytes.delete();
      if (last || mWordCount == 32) begin
        mActive = 1'b0;
        mDone   = 1'b1;
      end
    end
  endfunction

  function automatic void clearQueues();
    expAddr.delete();
    expData.delete();
    capAddr.delete();
    capData.delete();
    capCount.delete();
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!mActive) begin
      mActive    = 1'b1;
      mDone      = 1'b0;
      mWordCount = 0;
      mBytes.delete();
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mActive    = 1'b0;
    mDone      = 1'b0;
    mWordCount = 0;
    mBytes.delete();
  endtask

  // Offer one byte for one cycle; report what the model expects for
  // byte_ready and what the loader showed before the edge.
  task automatic sendByte(input logic [7:0] b, input bit last,
                          output bit expReady, output logic obsReady);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    expReady   = mActive;
    @(negedge clk);
    obsReady = byte_ready;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (expReady) modelAccept(b, last);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    idleCycles(2);
    reset = 1'b0;
    start = 1'b0;
    #1;
    checks += 7;
    if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
    if (wr_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_addr got %h want 0", wr_addr); end
    if (wr_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_data got %h want 0", wr_data); end
    if (word_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_word_count got %0d want 0", word_count); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_byte_ready got %b want 0", byte_ready); end
  endtask

  task automatic test_full_word();
    bit er; logic ob;
    logic [7:0] img[4] = '{8'h8C, 8'h01, 8'h00, 8'h04};
    clearQueues();
    pulseStart();
    checks += 4;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full_busy got %b want 1", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL full_done_low got %b want 0", done); end
    if (word_count !== 6'd0) begin errors++; $display("[TB] FAIL full_count0 got %0d want 0", word_count); end
    if (byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready got %b want 1", byte_ready); end
    for (int i = 0; i < 4; i++) sendByte(img[i], i == 3, er, ob);
    idleCycles(3);
    checks += 4;
    if (capAddr.size() != 1) begin
      errors++; $display("[TB] FAIL full_writes got %0d want 1", capAddr.size());
    end else begin
      if (capAddr[0] !== 32'h0) begin errors++; $display("[TB] FAIL full_addr got %h want 0", capAddr[0]); end
      if (capData[0] !== 32'h8C010004) begin errors++; $display("[TB] FAIL full_data got %h want 8c010004", capData[0]); end
      if (capCount[0] !== 6'd1) begin errors++; $display("[TB] FAIL full_count_at_write got %0d want 1", capCount[0]); end
    end
    checks += 3;
    if (word_count !== 6'd1) begin errors++; $display("[TB] FAIL full_count got %0d want 1", word_count); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL full_done got %b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_end got %b want 0", busy); end
  endtask

  task automatic test_partial_word();
    bit er; logic ob;
    clearQueues();
    pulseStart();
    sendByte(8'h20, 1'b0, er, ob);
    pulseStart();
    checks += 1;
    if (busy !== 1'b1 || word_count !== 6'd0) begin
      errors++; $display("[TB] FAIL partial_start_ignored busy %b count %0d want 1 0", busy, word_count);
    end
    sendByte(8'h02, 1'b1, er, ob);
    idleCycles(3);
    checks += 3;
    if (capAddr.size() != 1) begin
      errors++; $display("[TB] FAIL partial_writes got %0d want 1", capAddr.size());
    end else begin
      if (capAddr[0] !== 32'h0) begin errors++; $display("[TB] FAIL partial_addr got %h want 0", capAddr[0]); end
      if (capData[0] !== 32'h20020000) begin errors++; $display("[TB] FAIL partial_data got %h want 20020000", capData[0]); end
    end
    checks += 1;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL partial_done got %b want 1", done); end
  endtask

  task automatic test_capacity();
    bit er; logic ob;
    clearQueues();
    pulseStart();
    for (int i = 0; i < 130; i++) begin
      sendByte(8'($urandom), 1'b0, er, ob);
      checks++;
      if (ob !== er || (i >= 128 && ob !== 1'b0)) begin
        errors++; $display("[TB] FAIL capacity_ready byte %0d got %b want %b", i + 1, ob, er);
      end
    end
    idleCycles(3);
    checks += 1;
    if (capAddr.size() != 32 || expAddr.size() != 32) begin
      errors++; $display("[TB] FAIL capacity_writes got %0d want 32", capAddr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (capAddr[i] !== expAddr[i] || capData[i] !== expData[i]) begin
          errors++; $display("[TB] FAIL capacity_word %0d got %h/%h want %h/%h", i, capAddr[i], capData[i], expAddr[i], expData[i]);
        end
      end
      checks++;
      if (capAddr[31] !== 32'h7C) begin errors++; $display("[TB] FAIL capacity_last_addr got %h want 7c", capAddr[31]); end
    end
    checks += 2;
    if (word_count !== 6'd32) begin errors++; $display("[TB] FAIL capacity_count got %0d want 32", word_count); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL capacity_done got %b want 1", done); end
  endtask

  task automatic test_gaps();
    bit er; logic ob;
    clearQueues();
    pulseStart();
    for (int i = 0; i < 8; i++) begin
      sendByte(8'($urandom), i == 7, er, ob);
      idleCycles(1);
    end
    idleCycles(2);
    checks += 1;
    if (capAddr.size() != 2 || expAddr.size() != 2) begin
      errors++; $display("[TB] FAIL gaps_writes got %0d want 2", capAddr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (capAddr[i] !== 32'(i * 4) || capData[i] !== expData[i]) begin
          errors++; $display("[TB] FAIL gaps_word %0d got %h/%h want %h/%h", i, capAddr[i], capData[i], 32'(i * 4), expData[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    bit er; logic ob;
    pulseStart();
    for (int i = 0; i < 10; i++) sendByte(8'($urandom), 1'b0, er, ob);
    clearQueues();
    // Reset arrives together with a last byte that would otherwise complete word 3
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    byte_last  = 1'b1;
    applyReset();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    idleCycles(3);
    checks += 8;
    if (capAddr.size() != 0) begin errors++; $display("[TB] FAIL midreset_writes got %0d want 0", capAddr.size()); end
    if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_wr_en got %b want 0", wr_en); end
    if (wr_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_wr_addr got %h want 0", wr_addr); end
    if (wr_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset_wr_data got %h want 0", wr_data); end
    if (word_count !== 6'd0) begin errors++; $display("[TB] FAIL midreset_count got %0d want 0", word_count); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done); end
    if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready got %b want 0", byte_ready); end
  endtask

  task automatic test_restart_after_reset();
    bit er; logic ob;
    clearQueues();
    pulseStart();
    for (int i = 0; i < 4; i++) sendByte(8'($urandom), i == 3, er, ob);
    idleCycles(2);
    checks += 1;
    if (capAddr.size() != 1 || expData.size() != 1) begin
      errors++; $display("[TB] FAIL restart_writes got %0d want 1", capAddr.size());
    end else begin
      checks++;
      if (capAddr[0] !== 32'h0 || capData[0] !== expData[0]) begin
        errors++; $display("[TB] FAIL restart_word got %h/%h want 0/%h", capAddr[0], capData[0], expData[0]);
      end
    end
  endtask

  task automatic test_restart_from_done();
    bit er; logic ob;
    clearQueues();
    checks += 1;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL redone_pre_done got %b want 1", done); end
    pulseStart();
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL redone_done got %b want 0", done); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL redone_busy got %b want 1", busy); end
    if (word_count !== 6'd0) begin errors++; $display("[TB] FAIL redone_count got %0d want 0", word_count); end
    sendByte(8'h13, 1'b0, er, ob);
    sendByte(8'h57, 1'b1, er, ob);
    idleCycles(2);
    checks += 1;
    if (capAddr.size() != 1) begin
      errors++; $display("[TB] FAIL redone_writes got %0d want 1", capAddr.size());
    end else begin
      checks++;
      if (capAddr[0] !== 32'h0 || capData[0] !== 32'h13570000) begin
        errors++; $display("[TB] FAIL redone_word got %h/%h want 0/13570000", capAddr[0], capData[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit er; logic ob;
    int len;
    for (int s = 0; s < 4; s++) begin
      clearQueues();
      pulseStart();
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        if ($urandom_range(0, 9) == 0) pulseStart();
        sendByte(8'($urandom), i == len - 1, er, ob);
        checks++;
        if (ob !== er) begin errors++; $display("[TB] FAIL b2b_ready s%0d byte %0d got %b want %b", s, i, ob, er); end
      end
      idleCycles(2);
      checks += 1;
      if (capAddr.size() != expAddr.size()) begin
        errors++; $display("[TB] FAIL b2b_writes s%0d got %0d want %0d", s, capAddr.size(), expAddr.size());
      end else begin
        for (int i = 0; i < expAddr.size(); i++) begin
          checks++;
          if (capAddr[i] !== expAddr[i] || capData[i] !== expData[i] || capCount[i] !== 6'(i + 1)) begin
            errors++; $display("[TB] FAIL b2b_word s%0d w%0d got %h/%h/%0d want %h/%h/%0d", s, i, capAddr[i], capData[i], capCount[i], expAddr[i], expData[i], i + 1);
          end
        end
      end
      checks += 2;
      if (word_count !== 6'(mWordCount)) begin errors++; $display("[TB] FAIL b2b_count s%0d got %0d want %0d", s, word_count, mWordCount); end
      if (done !== mDone) begin errors++; $display("[TB] FAIL b2b_done s%0d got %b want %b", s, done, mDone); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    mActive    = 1'b0;
    mDone      = 1'b0;
    mWordCount = 0;
    test_reset();
    test_full_word();
    test_partial_word();
    test_capacity();
    test_gaps();
    test_reset_mid_word();
    test_restart_after_reset();
    test_restart_from_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 32: instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 32: width of the write byte address.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a load session.
REQ-006 Port byte_valid  input  1  a byte is offered on byte_data.
REQ-007 Port byte_data  input  8  offered byte.
REQ-008 Port byte_last  input  1  marks the offered byte as the final byte of the image.
REQ-009 Port byte_ready  output  1  loader accepts the offered byte this cycle.
REQ-010 Port wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-011 Port wr_addr  output  AW  byte address of the written word, always word-aligned (word index << 2).
REQ-012 Port wr_data  output  32  word to write.
REQ-013 Port busy  output  1  high while the session is in LOAD.
REQ-014 Port done  output  1  high while the session is in DONE.
REQ-015 Port word_count  output  6  number of words written in the current session, 0..DEPTH.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD and DONE.
REQ-017 IDLE -> LOAD when start=1: clear word_count, byte lane index and the assembly register.
REQ-018 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 exactly in LOAD; it is combinational from the state only.
REQ-020 Bytes SHALL pack big-endian: 1st accepted byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-021 Accepting a 4th byte, or a byte with byte_last=1, SHALL assert wr_en on the next cycle for exactly one cycle.
REQ-022 In that wr_en cycle, wr_addr = word_count_before_write << 2 and wr_data = the assembled word.
REQ-023 word_count SHALL increment in that same wr_en cycle.
REQ-024 When byte_last ends a partial word, the unfilled lower byte lanes SHALL be written as 0x00.
REQ-025 LOAD -> DONE when either the write triggered by byte_last issues, or the write of word DEPTH-1 issues, whichever comes first.
REQ-026 Bytes offered after the transition to DONE SHALL be refused (byte_ready=0).
REQ-027 byte_last on the 4th byte of a word SHALL produce one write only, not an extra all-zero word.
REQ-028 A byte MAY be accepted in the same cycle as the wr_en of the previous word; a single byte SHALL be accepted per cycle at most.
REQ-029 start SHALL be ignored in LOAD.
REQ-030 start in DONE SHALL behave as in REQ-017: the session restarts and done falls.
REQ-031 wr_en, wr_addr and wr_data SHALL be registered outputs.
REQ-032 wr_addr and wr_data SHALL hold their last written value when wr_en=0.

Reset
REQ-033 When reset=1 at a rising edge, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL set wr_en, wr_addr, wr_data, word_count, busy, done and the lane index to 0, and SHALL discard any partial word.
REQ-035 Reset SHALL take priority over start and over byte acceptance in the same cycle.
REQ-036 Reset in LOAD SHALL abort the session with no further wr_en.

Structure
REQ-037 A shared package SHALL hold IMEM_DEPTH (32), WORD_BYTES (4) and the loader state enumeration, so that the memory and the loader agree on them.
REQ-038 Byte-lane packing (lane index, shift-in, zero-fill, word-complete flag) SHALL be a sub-module named word_assembler.
REQ-039 The FSM, the counters and the write port SHALL live in instr_mem_loader.

Verification
REQ-040 Full-word load: start, then bytes 8C,01,00,04 with byte_last on the 4th -> one wr_en, wr_addr=0x0, wr_data=0x8C010004, word_count=1, done=1.
REQ-041 Partial word: bytes 20,02 with byte_last on the 2nd -> wr_data=0x20020000, wr_addr=0x0, done=1.
REQ-042 Capacity: 130 bytes streamed with no byte_last -> 32 writes, last at wr_addr=0x7C; byte_ready=0 from the 129th byte on; done=1, word_count=32.
REQ-043 Back-pressure and gaps: byte_valid toggling every other cycle over 8 bytes (last on the 8th) -> 2 writes, at 0x0 and 0x4, with correct data and no lost or duplicated byte.
REQ-044 Reset mid-word: reset after 2 bytes of word 3 -> no wr_en, all outputs 0, IDLE.
REQ-045 Reset mid-word, restart: after REQ-044, start and stream a new image -> first write at wr_addr=0x0.
REQ-046 Restart from DONE: start while done=1 -> done=0, busy=1, word_count=0, next write at wr_addr=0x0.
